// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the unified memory between instruction fetch and load/store.
// Optional build macro MISALIGN_CHK_EN turns misaligned accesses into error responses.
module mem_arbiter #(
   parameter int BUS_WIDTH  = 32,
   parameter int MEM_BYTES  = 64,
   parameter int ACC_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [BUS_WIDTH-1:0] if_addr,
   output logic                 if_gnt,
   output logic                 if_rvalid,
   output logic [BUS_WIDTH-1:0] if_rdata,
   output logic                 if_err,
   input  logic                 ls_req,
   input  logic                 ls_we,
   input  logic [BUS_WIDTH-1:0] ls_addr,
   input  logic [BUS_WIDTH-1:0] ls_wdata,
   input  logic [1:0]           ls_size,
   input  logic                 ls_sext,
   output logic                 ls_gnt,
   output logic                 ls_rvalid,
   output logic [BUS_WIDTH-1:0] ls_rdata,
   output logic                 ls_err,
   output logic [BUS_WIDTH-1:0] mem_address,
   output logic [BUS_WIDTH-1:0] mem_data_in,
   output logic                 mem_wr_en,
   output logic [1:0]           mem_size,
   output logic                 mem_sz_ex,
   input  logic [BUS_WIDTH-1:0] mem_data_out,
   output logic                 busy
);

   // state    | meaning
   // S_IDLE   | waiting for a request; grants are only issued here
   // S_ACCESS | mem driven from latched fields for ACC_CYCLES cycles
   // S_RESP   | one-cycle rvalid strobe on the granted port
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(ACC_CYCLES - 1);
   localparam logic [BUS_WIDTH:0] MEM_LIM = (BUS_WIDTH + 1)'(MEM_BYTES);
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 rr_last_q, rr_last_d;
   logic                 sel_ls_q, sel_ls_d;
   logic                 we_q, we_d;
   logic [BUS_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]           size_q, size_d;
   logic                 sext_q, sext_d;
   logic                 err_q, err_d;
   logic                 if_rvalid_q, if_rvalid_d;
   logic [BUS_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic                 if_err_q, if_err_d;
   logic                 ls_rvalid_q, ls_rvalid_d;
   logic [BUS_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
   logic                 ls_err_q, ls_err_d;

   logic                 gnt_if, gnt_ls;
   logic [2:0]           ls_nbytes;
   logic [BUS_WIDTH:0]   ls_end, if_end;
   logic                 ls_fault, if_fault;
   logic [BUS_WIDTH-1:0] resp_data;
   logic                 last_cycle;

   // rr_last_q: 0 = IF granted last, 1 = LS granted last
   always_comb begin
      gnt_ls = 1'b0;
      gnt_if = 1'b0;
      if (state_q == S_IDLE) begin
         gnt_ls = ls_req && (!if_req || !rr_last_q);
         gnt_if = if_req && !gnt_ls;
      end
   end

   always_comb begin
      case (ls_size)
         2'b00:   ls_nbytes = 3'd1;
         2'b01:   ls_nbytes = 3'd2;
         default: ls_nbytes = 3'd4;
      endcase
      ls_end   = {1'b0, ls_addr} + (BUS_WIDTH + 1)'(ls_nbytes);
      if_end   = {1'b0, if_addr} + (BUS_WIDTH + 1)'(4);
      ls_fault = (ls_size == 2'b11) || (ls_end > MEM_LIM);
      if_fault = (if_end > MEM_LIM);
`ifdef MISALIGN_CHK_EN
      if ((ls_size == 2'b01 && ls_addr[0]) || (ls_size == 2'b10 && ls_addr[1:0] != 2'b00))
         ls_fault = 1'b1;
      if (if_addr[1:0] != 2'b00)
         if_fault = 1'b1;
`endif
   end

   assign last_cycle = (state_q == S_ACCESS) && (cnt_q == '0);
   assign resp_data  = (err_q || we_q) ? '0 : mem_data_out;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_last_d   = rr_last_q;
      sel_ls_d    = sel_ls_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      sext_d      = sext_q;
      err_d       = err_q;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      if_err_d    = if_err_q;
      ls_rvalid_d = 1'b0;
      ls_rdata_d  = ls_rdata_q;
      ls_err_d    = ls_err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_ls) begin
               state_d   = S_ACCESS;
               cnt_d     = CNT_INIT;
               rr_last_d = 1'b1;
               sel_ls_d  = 1'b1;
               we_d      = ls_we;
               addr_d    = ls_addr;
               wdata_d   = ls_wdata;
               size_d    = ls_size;
               sext_d    = ls_sext;
               err_d     = ls_fault;
            end else if (gnt_if) begin
               state_d   = S_ACCESS;
               cnt_d     = CNT_INIT;
               rr_last_d = 1'b0;
               sel_ls_d  = 1'b0;
               we_d      = 1'b0;
               addr_d    = if_addr;
               wdata_d   = '0;
               size_d    = SZ_WORD;
               sext_d    = 1'b0;
               err_d     = if_fault;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               if (sel_ls_q) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = resp_data;
                  ls_err_d    = err_q;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = resp_data;
                  if_err_d    = err_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rr_last_q   <= 1'b0;
         sel_ls_q    <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= SZ_WORD;
         sext_q      <= 1'b0;
         err_q       <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         ls_rvalid_q <= 1'b0;
         ls_rdata_q  <= '0;
         ls_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_last_q   <= rr_last_d;
         sel_ls_q    <= sel_ls_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         err_q       <= err_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         ls_rvalid_q <= ls_rvalid_d;
         ls_rdata_q  <= ls_rdata_d;
         ls_err_q    <= ls_err_d;
      end
   end

   // mem port is a pure decode of registered state, so reset drops wr_en immediately
   always_comb begin
      mem_address = '0;
      mem_data_in = '0;
      mem_wr_en   = 1'b0;
      mem_size    = SZ_WORD;
      mem_sz_ex   = 1'b0;
      if (state_q == S_ACCESS) begin
         mem_address = addr_q;
         mem_data_in = wdata_q;
         mem_size    = size_q;
         mem_sz_ex   = sext_q;
         mem_wr_en   = last_cycle && we_q && !err_q;
      end
   end

   assign if_gnt    = gnt_if;
   assign ls_gnt    = gnt_ls;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign ls_rvalid = ls_rvalid_q;
   assign ls_rdata  = ls_rdata_q;
   assign ls_err    = ls_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64-byte little-endian memory.
// Build with MISALIGN_CHK_EN defined to exercise the misalignment-error variant.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        ls_req, ls_we, ls_sext;
   logic [31:0] ls_addr, ls_wdata;
   logic [1:0]  ls_size;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic [31:0] ls_rdata;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        mem_wr_en, mem_sz_ex, busy;
   logic [1:0]  mem_size;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int ls_rv_cnt = 0;

   logic [7:0] mem [64];

   always #5 clk = ~clk;

   mem_arbiter #(.BUS_WIDTH(32), .MEM_BYTES(64), .ACC_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_size(ls_size), .ls_sext(ls_sext), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
      .mem_size(mem_size), .mem_sz_ex(mem_sz_ex), .mem_data_out(mem_data_out),
      .busy(busy)
   );

   function automatic logic [7:0] rd_byte(input logic [31:0] a, input int k);
      logic [32:0] ea;
      ea = {1'b0, a} + 33'(k);
      if (ea < 33'd64) return mem[ea[5:0]];
      return 8'h00;
   endfunction

   always_comb begin
      logic [7:0] b0, b1, b2, b3;
      b0 = rd_byte(mem_address, 0);
      b1 = rd_byte(mem_address, 1);
      b2 = rd_byte(mem_address, 2);
      b3 = rd_byte(mem_address, 3);
      case (mem_size)
         2'b00:   mem_data_out = {{24{mem_sz_ex & b0[7]}}, b0};
         2'b01:   mem_data_out = {{16{mem_sz_ex & b1[7]}}, b1, b0};
         2'b10:   mem_data_out = {b3, b2, b1, b0};
         default: mem_data_out = 32'h0;
      endcase
   end

   always @(negedge clk) begin
      if (mem_wr_en) begin
         wr_cnt++;
         for (int k = 0; k < 4; k++) begin
            if ((k == 0 || (k == 1 && mem_size != 2'b00) || (k >= 2 && mem_size == 2'b10))
                && ({1'b0, mem_address} + 33'(k) < 33'd64))
               mem[mem_address[5:0] + 6'(k)] = mem_data_in[8*k +: 8];
         end
      end
      if (ls_rvalid) ls_rv_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ls_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sext,
                          output logic gnt_ok, output logic rv_early, output logic rv_ok,
                          output logic [31:0] rdata, output logic err);
      int n;
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
      ls_size = size; ls_sext = sext;
      #1;
      n = 0;
      while (!ls_gnt && n < 10) begin step(); n++; end
      gnt_ok = ls_gnt;
      step();
      ls_req = 1'b0;
      rv_early = ls_rvalid;
      step();
      rv_ok = ls_rvalid; rdata = ls_rdata; err = ls_err;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++;
      if (if_gnt !== 0 || ls_gnt !== 0 || if_rvalid !== 0 || ls_rvalid !== 0 || busy !== 0) begin
         errors++; $display("FAIL reset_ctrl: gnt=%b%b rvalid=%b%b busy=%b, required all 0",
                            if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy);
      end
      checks++;
      if (if_rdata !== 0 || ls_rdata !== 0 || if_err !== 0 || ls_err !== 0) begin
         errors++; $display("FAIL reset_data: if_rdata=%h ls_rdata=%h errs=%b%b, required 0",
                            if_rdata, ls_rdata, if_err, ls_err);
      end
      checks++;
      if (mem_size !== 2'b10 || mem_address !== 0 || mem_data_in !== 0 || mem_wr_en !== 0
          || mem_sz_ex !== 0) begin
         errors++; $display("FAIL reset_mem: size=%b addr=%h data=%h we=%b sx=%b, required 10/0/0/0/0",
                            mem_size, mem_address, mem_data_in, mem_wr_en, mem_sz_ex);
      end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_if_fetch();
      int n;
      logic early;
      if_req = 1'b1; if_addr = 32'h0;
      #1;
      n = 0;
      while (!if_gnt && n < 10) begin step(); n++; end
      checks++;
      if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
         errors++; $display("FAIL if_gnt: if_gnt=%b ls_gnt=%b, required 1/0", if_gnt, ls_gnt);
      end
      step();
      if_req = 1'b0;
      early = if_rvalid;
      checks++;
      if (early !== 1'b0 || busy !== 1'b1 || mem_size !== 2'b10 || mem_wr_en !== 1'b0) begin
         errors++; $display("FAIL if_access: rvalid=%b busy=%b size=%b we=%b, required 0/1/10/0",
                            early, busy, mem_size, mem_wr_en);
      end
      step();
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h00110113 || if_err !== 1'b0) begin
         errors++; $display("FAIL if_resp: rvalid=%b rdata=%h err=%b, required 1/00110113/0",
                            if_rvalid, if_rdata, if_err);
      end
      step();
      checks++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'h00110113) begin
         errors++; $display("FAIL if_hold: rvalid=%b rdata=%h, required 0/00110113",
                            if_rvalid, if_rdata);
      end
   endtask

   task automatic test_store_load();
      logic g, e, v, er;
      logic [31:0] d;
      int w0;
      w0 = wr_cnt;
      ls_xact(1'b1, 32'd16, 32'hDEADBEEF, 2'b10, 1'b0, g, e, v, d, er);
      checks++;
      if (g !== 1 || e !== 0 || v !== 1 || d !== 32'h0 || er !== 0 || wr_cnt != w0 + 1) begin
         errors++; $display("FAIL store_resp: gnt=%b early=%b rv=%b rdata=%h err=%b writes=%0d, required 1/0/1/0/0/1",
                            g, e, v, d, er, wr_cnt - w0);
      end
      checks++;
      if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEADBEEF) begin
         errors++; $display("FAIL store_bytes: got %h, required deadbeef",
                            {mem[19], mem[18], mem[17], mem[16]});
      end
      ls_xact(1'b0, 32'd19, 32'h0, 2'b00, 1'b1, g, e, v, d, er);
      checks++;
      if (v !== 1 || d !== 32'hFFFFFFDE || er !== 0) begin
         errors++; $display("FAIL load_byte_sext: rv=%b rdata=%h err=%b, required 1/ffffffde/0", v, d, er);
      end
      ls_xact(1'b0, 32'd19, 32'h0, 2'b00, 1'b0, g, e, v, d, er);
      checks++;
      if (v !== 1 || d !== 32'h000000DE || er !== 0) begin
         errors++; $display("FAIL load_byte_zext: rv=%b rdata=%h err=%b, required 1/000000de/0", v, d, er);
      end
      ls_xact(1'b0, 32'd18, 32'h0, 2'b01, 1'b1, g, e, v, d, er);
      checks++;
      if (v !== 1 || d !== 32'hFFFFDEAD || er !== 0) begin
         errors++; $display("FAIL load_half_sext: rv=%b rdata=%h err=%b, required 1/ffffdead/0", v, d, er);
      end
      step();
      checks++;
      if (ls_rdata !== 32'hFFFFDEAD || ls_rvalid !== 1'b0) begin
         errors++; $display("FAIL ls_hold: rdata=%h rvalid=%b, required ffffdead/0", ls_rdata, ls_rvalid);
      end
   endtask

   task automatic test_round_robin();
      int n;
      logic exp_ls;
      rst = 1'b0;
      step();
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h0;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8; ls_size = 2'b10; ls_sext = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!(if_gnt || ls_gnt) && n < 10) begin step(); n++; end
         exp_ls = (k % 2 == 0);
         checks++;
         if (ls_gnt !== exp_ls || if_gnt !== !exp_ls) begin
            errors++; $display("FAIL rr_grant%0d: ls_gnt=%b if_gnt=%b, required %b/%b",
                               k, ls_gnt, if_gnt, exp_ls, !exp_ls);
         end
         step();
         step();
         checks++;
         if (exp_ls) begin
            if (ls_rvalid !== 1 || if_rvalid !== 0 || ls_rdata !== 32'h4B4A4948) begin
               errors++; $display("FAIL rr_resp%0d: ls_rv=%b if_rv=%b ls_rdata=%h, required 1/0/4b4a4948",
                                  k, ls_rvalid, if_rvalid, ls_rdata);
            end
         end else begin
            if (if_rvalid !== 1 || ls_rvalid !== 0 || if_rdata !== 32'h00110113) begin
               errors++; $display("FAIL rr_resp%0d: if_rv=%b ls_rv=%b if_rdata=%h, required 1/0/00110113",
                                  k, if_rvalid, ls_rvalid, if_rdata);
            end
         end
         step();
      end
      if_req = 1'b0; ls_req = 1'b0;
      step();
   endtask

   task automatic test_range_err();
      logic g, e, v, er;
      logic [31:0] d;
      int w0;
      w0 = wr_cnt;
      ls_xact(1'b1, 32'd62, 32'h11223344, 2'b10, 1'b0, g, e, v, d, er);
      checks++;
      if (v !== 1 || er !== 1 || d !== 32'h0 || wr_cnt != w0) begin
         errors++; $display("FAIL store_oob: rv=%b err=%b rdata=%h writes=%0d, required 1/1/0/0",
                            v, er, d, wr_cnt - w0);
      end
      checks++;
      if (mem[62] !== 8'h7E || mem[63] !== 8'h7F) begin
         errors++; $display("FAIL oob_bytes: 62=%h 63=%h, required 7e/7f", mem[62], mem[63]);
      end
      ls_xact(1'b0, 32'd60, 32'h0, 2'b10, 1'b0, g, e, v, d, er);
      checks++;
      if (v !== 1 || er !== 0 || d !== 32'h7F7E7D7C) begin
         errors++; $display("FAIL load_edge: rv=%b err=%b rdata=%h, required 1/0/7f7e7d7c", v, er, d);
      end
      ls_xact(1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, g, e, v, d, er);
      checks++;
      if (v !== 1 || er !== 1 || d !== 32'h0) begin
         errors++; $display("FAIL load_wrap: rv=%b err=%b rdata=%h, required 1/1/0", v, er, d);
      end
      w0 = wr_cnt;
      ls_xact(1'b1, 32'd8, 32'hCAFEF00D, 2'b11, 1'b0, g, e, v, d, er);
      checks++;
      if (v !== 1 || er !== 1 || d !== 32'h0 || wr_cnt != w0 || mem[8] !== 8'h48) begin
         errors++; $display("FAIL size_err: rv=%b err=%b rdata=%h writes=%0d byte8=%h, required 1/1/0/0/48",
                            v, er, d, wr_cnt - w0, mem[8]);
      end
   endtask

   task automatic test_misalign();
      logic g, e, v, er;
      logic [31:0] d;
      ls_xact(1'b0, 32'd2, 32'h0, 2'b10, 1'b0, g, e, v, d, er);
      checks++;
`ifdef MISALIGN_CHK_EN
      if (v !== 1 || er !== 1 || d !== 32'h0) begin
         errors++; $display("FAIL misalign_word: rv=%b err=%b rdata=%h, required 1/1/0", v, er, d);
      end
`else
      if (v !== 1 || er !== 0 || d !== 32'h45440011) begin
         errors++; $display("FAIL misalign_word: rv=%b err=%b rdata=%h, required 1/0/45440011", v, er, d);
      end
`endif
   endtask

   task automatic test_reset_abort();
      int n, rv0;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd20; ls_wdata = 32'h12345678;
      ls_size = 2'b10; ls_sext = 1'b0;
      #1;
      n = 0;
      while (!ls_gnt && n < 10) begin step(); n++; end
      checks++;
      if (ls_gnt !== 1'b1) begin
         errors++; $display("FAIL abort_gnt: ls_gnt=%b, required 1", ls_gnt);
      end
      step();
      ls_req = 1'b0;
      checks++;
      if (mem_wr_en !== 1'b1) begin
         errors++; $display("FAIL abort_pre_we: mem_wr_en=%b, required 1", mem_wr_en);
      end
      rv0 = ls_rv_cnt;
      rst = 1'b0;
      #1;
      checks++;
      if (mem_wr_en !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_we: mem_wr_en=%b busy=%b, required 0/0", mem_wr_en, busy);
      end
      step();
      rst = 1'b1;
      repeat (4) step();
      checks++;
      if (ls_rv_cnt != rv0 || busy !== 1'b0 ||
          {mem[23], mem[22], mem[21], mem[20]} !== 32'h57565554) begin
         errors++; $display("FAIL abort_after: rvalids=%0d busy=%b bytes=%h, required 0/0/57565554",
                            ls_rv_cnt - rv0, busy, {mem[23], mem[22], mem[21], mem[20]});
      end
   endtask

   initial begin
      mem[0] = 8'h13; mem[1] = 8'h01; mem[2] = 8'h11; mem[3] = 8'h00;
      for (int i = 4; i < 64; i++) mem[i] = 8'(8'h40 + i);
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_size = 2'b10; ls_sext = 1'b0;
      test_reset();
      test_if_fetch();
      test_store_load();
      test_round_robin();
      test_range_err();
      test_misalign();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
